delay_exec_opnd_buf: RTL and testbench

- Parametrised successor to the per-ALU delayed-execution operand fix-up stage.
- Buffers up to DEPTH issued instructions whose source operands are still pending on a late producer (ALU1, ALU2, BRU link PC, MMU, HILO).
- Snoops NCH producer result channels over as many cycles as needed and releases instructions to the consuming ALU in order, once all operands are resolved.
- Sits between the issue stage and one execute unit; one instance per delayed-execution consumer.

---
 rtl/delay_exec_opnd_buf.sv | 234 +++++++++++++++++++++++
 tb/tb_delay_exec_opnd_buf.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_exec_opnd_buf.sv
// Delayed-execution operand buffer.
// Holds issued instructions whose source operands are still waiting on a late
// producer. It snoops the producer result channels every cycle, fills in the
// missing operands, and releases instructions in order to one execute unit.
module delay_exec_opnd_buf #(
    parameter int DEPTH = 4,
    parameter int NCH   = 5,
    parameter int DW    = 32,
    parameter int RW    = 5,
    parameter int TW    = 3,
    parameter int PW    = 16
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DW-1:0]                in_opA,
    input  logic [DW-1:0]                in_opB,
    input  logic                         in_pendA,
    input  logic                         in_pendB,
    input  logic [RW-1:0]                in_regA,
    input  logic [RW-1:0]                in_regB,
    input  logic [TW-1:0]                in_fuA,
    input  logic [TW-1:0]                in_fuB,
    input  logic [PW-1:0]                in_payload,
    input  logic [NCH-1:0]               res_valid,
    input  logic [NCH*RW-1:0]            res_reg,
    input  logic [NCH*DW-1:0]            res_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DW-1:0]                out_opA,
    output logic [DW-1:0]                out_opB,
    output logic [PW-1:0]                out_payload,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    // Look up the single channel named by the tag. Returns {hit, data}.
    // A tag outside the channel range never matches, so such an operand
    // stays pending forever.
    function automatic logic [DW:0] snoop(
        input logic [TW-1:0]     fu,
        input logic [RW-1:0]     rg,
        input logic [NCH-1:0]    rv,
        input logic [NCH*RW-1:0] rr,
        input logic [NCH*DW-1:0] rd
    );
        logic [DW:0] r;
        r = '0;
        for (int c = 0; c < NCH; c++) begin
            if (fu == TW'(c) && rv[c] && rr[c*RW +: RW] == rg) begin
                r = {1'b1, rd[c*DW +: DW]};
            end
        end
        return r;
    endfunction

    // Entry storage
    logic          valid_q   [DEPTH];
    logic [DW-1:0] opa_q     [DEPTH];
    logic [DW-1:0] opb_q     [DEPTH];
    logic          penda_q   [DEPTH];
    logic          pendb_q   [DEPTH];
    logic [RW-1:0] rega_q    [DEPTH];
    logic [RW-1:0] regb_q    [DEPTH];
    logic [TW-1:0] fua_q     [DEPTH];
    logic [TW-1:0] fub_q     [DEPTH];
    logic [PW-1:0] payload_q [DEPTH];

    logic          valid_d   [DEPTH];
    logic [DW-1:0] opa_d     [DEPTH];
    logic [DW-1:0] opb_d     [DEPTH];
    logic          penda_d   [DEPTH];
    logic          pendb_d   [DEPTH];
    logic [RW-1:0] rega_d    [DEPTH];
    logic [RW-1:0] regb_d    [DEPTH];
    logic [TW-1:0] fua_d     [DEPTH];
    logic [TW-1:0] fub_d     [DEPTH];
    logic [PW-1:0] payload_d [DEPTH];

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    // Per-entry snoop results for both operands
    logic [DW:0] snp_a [DEPTH];
    logic [DW:0] snp_b [DEPTH];
    logic [DW:0] snp_in_a;
    logic [DW:0] snp_in_b;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_snoop
            assign snp_a[gi] = snoop(fua_q[gi], rega_q[gi], res_valid, res_reg, res_data);
            assign snp_b[gi] = snoop(fub_q[gi], regb_q[gi], res_valid, res_reg, res_data);
        end
    endgenerate

    // The incoming instruction also snoops, so a result on its enqueue cycle is not lost
    assign snp_in_a = snoop(in_fuA, in_regA, res_valid, res_reg, res_data);
    assign snp_in_b = snoop(in_fuB, in_regB, res_valid, res_reg, res_data);

    logic enq_fire;
    logic deq_fire;

    assign in_ready  = (count_q < CW'(DEPTH));
    assign out_valid = valid_q[head_q] && !penda_q[head_q] && !pendb_q[head_q];
    assign out_opA     = out_valid ? opa_q[head_q]     : '0;
    assign out_opB     = out_valid ? opb_q[head_q]     : '0;
    assign out_payload = out_valid ? payload_q[head_q] : '0;
    assign count       = count_q;

    assign enq_fire = in_valid && in_ready;
    assign deq_fire = out_valid && out_ready;

    // Next state: operand capture, dequeue at head, enqueue at tail, flush override
    always_comb begin
        valid_d   = valid_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        penda_d   = penda_q;
        pendb_d   = pendb_q;
        rega_d    = rega_q;
        regb_d    = regb_q;
        fua_d     = fua_q;
        fub_d     = fub_q;
        payload_d = payload_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q + CW'(enq_fire) - CW'(deq_fire);

        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && penda_q[i] && snp_a[i][DW]) begin
                opa_d[i]   = snp_a[i][DW-1:0];
                penda_d[i] = 1'b0;
            end
            if (valid_q[i] && pendb_q[i] && snp_b[i][DW]) begin
                opb_d[i]   = snp_b[i][DW-1:0];
                pendb_d[i] = 1'b0;
            end
        end

        if (deq_fire) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + AW'(1);
        end

        if (enq_fire) begin
            valid_d[tail_q]   = 1'b1;
            rega_d[tail_q]    = in_regA;
            regb_d[tail_q]    = in_regB;
            fua_d[tail_q]     = in_fuA;
            fub_d[tail_q]     = in_fuB;
            payload_d[tail_q] = in_payload;
            // Register 0 is hard-wired to zero, so it is never really pending
            if (!in_pendA) begin
                opa_d[tail_q]   = in_opA;
                penda_d[tail_q] = 1'b0;
            end else if (in_regA == '0) begin
                opa_d[tail_q]   = '0;
                penda_d[tail_q] = 1'b0;
            end else if (snp_in_a[DW]) begin
                opa_d[tail_q]   = snp_in_a[DW-1:0];
                penda_d[tail_q] = 1'b0;
            end else begin
                opa_d[tail_q]   = in_opA;
                penda_d[tail_q] = 1'b1;
            end
            if (!in_pendB) begin
                opb_d[tail_q]   = in_opB;
                pendb_d[tail_q] = 1'b0;
            end else if (in_regB == '0) begin
                opb_d[tail_q]   = '0;
                pendb_d[tail_q] = 1'b0;
            end else if (snp_in_b[DW]) begin
                opb_d[tail_q]   = snp_in_b[DW-1:0];
                pendb_d[tail_q] = 1'b0;
            end else begin
                opb_d[tail_q]   = in_opB;
                pendb_d[tail_q] = 1'b1;
            end
            tail_d = tail_q + AW'(1);
        end

        // Flush wins over everything, including a same-cycle enqueue
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_d[i] = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i]   <= 1'b0;
                opa_q[i]     <= '0;
                opb_q[i]     <= '0;
                penda_q[i]   <= 1'b0;
                pendb_q[i]   <= 1'b0;
                rega_q[i]    <= '0;
                regb_q[i]    <= '0;
                fua_q[i]     <= '0;
                fub_q[i]     <= '0;
                payload_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q   <= valid_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            penda_q   <= penda_d;
            pendb_q   <= pendb_d;
            rega_q    <= rega_d;
            regb_q    <= regb_d;
            fua_q     <= fua_d;
            fub_q     <= fub_d;
            payload_q <= payload_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: tb/tb_delay_exec_opnd_buf.sv
// Bench for delay_exec_opnd_buf: directed scenarios plus a randomized run
// checked against a queue-based reference model.
module tb_delay_exec_opnd_buf;

    localparam int DEPTH = 4;
    localparam int NCH   = 5;
    localparam int DW    = 32;
    localparam int RW    = 5;
    localparam int TW    = 3;
    localparam int PW    = 16;

    logic              clk = 1'b0;
    logic              resetn = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DW-1:0]     in_opA = '0, in_opB = '0;
    logic              in_pendA = 1'b0, in_pendB = 1'b0;
    logic [RW-1:0]     in_regA = '0, in_regB = '0;
    logic [TW-1:0]     in_fuA = '0, in_fuB = '0;
    logic [PW-1:0]     in_payload = '0;
    logic [NCH-1:0]    res_valid;
    logic [NCH*RW-1:0] res_reg;
    logic [NCH*DW-1:0] res_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DW-1:0]     out_opA, out_opB;
    logic [PW-1:0]     out_payload;
    logic [2:0]        count;

    // Result channels kept as per-channel arrays and packed for the DUT
    logic          res_v [NCH];
    logic [RW-1:0] res_r [NCH];
    logic [DW-1:0] res_d [NCH];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always_comb begin
        res_valid = '0;
        res_reg   = '0;
        res_data  = '0;
        for (int c = 0; c < NCH; c++) begin
            res_valid[c]          = res_v[c];
            res_reg[c*RW +: RW]   = res_r[c];
            res_data[c*DW +: DW]  = res_d[c];
        end
    end

    delay_exec_opnd_buf #(
        .DEPTH(DEPTH), .NCH(NCH), .DW(DW), .RW(RW), .TW(TW), .PW(PW)
    ) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opA(in_opA), .in_opB(in_opB),
        .in_pendA(in_pendA), .in_pendB(in_pendB),
        .in_regA(in_regA), .in_regB(in_regB),
        .in_fuA(in_fuA), .in_fuB(in_fuB),
        .in_payload(in_payload),
        .res_valid(res_valid), .res_reg(res_reg), .res_data(res_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opA(out_opA), .out_opB(out_opB), .out_payload(out_payload),
        .count(count)
    );

    // Pending operands must always carry a legal producer tag
    always @(posedge clk) begin
        if (resetn && in_valid && in_ready) begin
            if (in_pendA && in_regA != '0) assert (int'(in_fuA) < NCH) else $error("illegal fuA tag %0d", in_fuA);
            if (in_pendB && in_regB != '0) assert (int'(in_fuB) < NCH) else $error("illegal fuB tag %0d", in_fuB);
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [DW-1:0] opa, opb;
        bit            pa, pb;
        logic [RW-1:0] ra, rb;
        logic [TW-1:0] fa, fb;
        logic [PW-1:0] pl;
    } ent_t;

    ent_t mq[$];

    function automatic bit mdl_snoop(input logic [TW-1:0] fu, input logic [RW-1:0] r, output logic [DW-1:0] d);
        int idx;
        d   = '0;
        idx = int'(fu);
        if (idx >= NCH) return 1'b0;
        if (res_v[idx] && res_r[idx] == r) begin
            d = res_d[idx];
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge
    task automatic model_step();
        bit ov, deq, enq;
        ent_t e;
        logic [DW-1:0] d;
        if (!resetn) begin
            mq.delete();
            return;
        end
        ov  = mq.size() > 0 && !mq[0].pa && !mq[0].pb;
        deq = ov && out_ready;
        enq = in_valid && mq.size() < DEPTH;
        if (flush) begin
            mq.delete();
            return;
        end
        foreach (mq[i]) begin
            if (mq[i].pa && mdl_snoop(mq[i].fa, mq[i].ra, d)) begin mq[i].opa = d; mq[i].pa = 1'b0; end
            if (mq[i].pb && mdl_snoop(mq[i].fb, mq[i].rb, d)) begin mq[i].opb = d; mq[i].pb = 1'b0; end
        end
        if (deq) void'(mq.pop_front());
        if (enq) begin
            e.opa = in_opA; e.opb = in_opB; e.pa = in_pendA; e.pb = in_pendB;
            e.ra = in_regA; e.rb = in_regB; e.fa = in_fuA; e.fb = in_fuB; e.pl = in_payload;
            if (e.pa && e.ra == '0) begin e.pa = 1'b0; e.opa = '0; end
            else if (e.pa && mdl_snoop(e.fa, e.ra, d)) begin e.pa = 1'b0; e.opa = d; end
            if (e.pb && e.rb == '0) begin e.pb = 1'b0; e.opb = '0; end
            else if (e.pb && mdl_snoop(e.fb, e.rb, d)) begin e.pb = 1'b0; e.opb = d; end
            mq.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_in();
        in_valid = 1'b0; flush = 1'b0;
        in_opA = '0; in_opB = '0; in_pendA = 1'b0; in_pendB = 1'b0;
        in_regA = '0; in_regB = '0; in_fuA = '0; in_fuB = '0; in_payload = '0;
        for (int c = 0; c < NCH; c++) begin
            res_v[c] = 1'b0; res_r[c] = '0; res_d[c] = '0;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clear_in();
        #1 resetn = 1'b0;
        #3;
        total++;
        if ({in_ready, out_valid, count, out_opA, out_opB, out_payload} !== {1'b1, 1'b0, 3'd0, 32'h0, 32'h0, 16'h0}) begin
            bad++;
            $display("FAIL reset_state got rdy=%0b v=%0b cnt=%0d a=%h b=%h p=%h want rdy=1 v=0 cnt=0 a/b/p=0",
                     in_ready, out_valid, count, out_opA, out_opB, out_payload);
        end
        tick(); tick();
        resetn = 1'b1;
        tick();
        total++;
        if ({in_ready, out_valid, count} !== {1'b1, 1'b0, 3'd0}) begin
            bad++;
            $display("FAIL post_reset got rdy=%0b v=%0b cnt=%0d want 1/0/0", in_ready, out_valid, count);
        end
        $display("reset: rdy=%0b cnt=%0d", in_ready, count);
    endtask

    task automatic test_passthru();
        clear_in(); out_ready = 1'b1;
        in_valid = 1'b1; in_opA = 32'h11; in_opB = 32'h22; in_payload = 16'hA001;
        tick(); clear_in();
        total++;
        if ({out_valid, out_opA, out_opB, out_payload, count} !== {1'b1, 32'h11, 32'h22, 16'hA001, 3'd1}) begin
            bad++;
            $display("FAIL passthru_out got v=%0b a=%h b=%h p=%h cnt=%0d want 1/11/22/a001/1",
                     out_valid, out_opA, out_opB, out_payload, count);
        end
        tick();
        total++;
        if ({out_valid, count} !== {1'b0, 3'd0}) begin
            bad++;
            $display("FAIL passthru_drain got v=%0b cnt=%0d want 0/0", out_valid, count);
        end
        $display("passthru: a=11 b=22 released");
    endtask

    task automatic test_late_bru();
        clear_in(); out_ready = 1'b1;
        in_valid = 1'b1; in_pendA = 1'b1; in_regA = 5'd8; in_fuA = 3'd2; in_opB = 32'h5; in_payload = 16'hA002;
        tick(); clear_in();
        total++;
        if ({out_valid, count} !== {1'b0, 3'd1}) begin
            bad++;
            $display("FAIL bru_wait got v=%0b cnt=%0d want 0/1", out_valid, count);
        end
        // wrong register on the right channel, right register on the wrong channel
        res_v[2] = 1'b1; res_r[2] = 5'd7; res_d[2] = 32'h999;
        res_v[4] = 1'b1; res_r[4] = 5'd8; res_d[4] = 32'h888;
        tick(); clear_in();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bru_decoy got v=%0b want 0", out_valid);
        end
        res_v[2] = 1'b1; res_r[2] = 5'd8; res_d[2] = 32'hBFC00008;
        tick(); clear_in();
        total++;
        if ({out_valid, out_opA, out_opB, out_payload} !== {1'b1, 32'hBFC00008, 32'h5, 16'hA002}) begin
            bad++;
            $display("FAIL bru_release got v=%0b a=%h b=%h p=%h want 1/bfc00008/5/a002",
                     out_valid, out_opA, out_opB, out_payload);
        end
        tick();
        total++;
        if (count !== 3'd0) begin
            bad++;
            $display("FAIL bru_drain got cnt=%0d want 0", count);
        end
        $display("late_bru: a=bfc00008 captured");
    endtask

    task automatic test_enq_capture();
        clear_in(); out_ready = 1'b1;
        in_valid = 1'b1; in_pendB = 1'b1; in_regB = 5'd3; in_fuB = 3'd4; in_opA = 32'h77; in_payload = 16'hA003;
        res_v[4] = 1'b1; res_r[4] = 5'd3; res_d[4] = 32'hDEAD;
        tick(); clear_in();
        total++;
        if ({out_valid, out_opA, out_opB} !== {1'b1, 32'h77, 32'hDEAD}) begin
            bad++;
            $display("FAIL enqcap_out got v=%0b a=%h b=%h want 1/77/dead", out_valid, out_opA, out_opB);
        end
        tick();
        // same register reported on a different channel must not resolve it
        in_valid = 1'b1; in_pendB = 1'b1; in_regB = 5'd3; in_fuB = 3'd4;
        res_v[1] = 1'b1; res_r[1] = 5'd3; res_d[1] = 32'hBAD;
        tick(); clear_in();
        total++;
        if ({out_valid, count} !== {1'b0, 3'd1}) begin
            bad++;
            $display("FAIL wrongch_enq got v=%0b cnt=%0d want 0/1", out_valid, count);
        end
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL wrongch_hold got v=%0b want 0", out_valid);
        end
        res_v[4] = 1'b1; res_r[4] = 5'd3; res_d[4] = 32'hBEEF;
        tick(); clear_in();
        total++;
        if ({out_valid, out_opB} !== {1'b1, 32'hBEEF}) begin
            bad++;
            $display("FAIL wrongch_release got v=%0b b=%h want 1/beef", out_valid, out_opB);
        end
        tick();
        $display("enq_capture: b=dead at enqueue, b=beef later");
    endtask

    task automatic test_fill_wrap();
        logic [DW-1:0] exp_a [4];
        clear_in(); out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1;
            in_pendA = (i == 0); in_regA = 5'd5; in_fuA = 3'd0;
            in_opA = 32'h100 + 32'(i); in_payload = 16'hB000 + 16'(i);
            tick();
        end
        clear_in();
        total++;
        if ({in_ready, out_valid, count} !== {1'b0, 1'b0, 3'd4}) begin
            bad++;
            $display("FAIL fill_full got rdy=%0b v=%0b cnt=%0d want 0/0/4", in_ready, out_valid, count);
        end
        in_valid = 1'b1; in_opA = 32'h999;
        tick(); clear_in();
        total++;
        if ({out_valid, count} !== {1'b0, 3'd4}) begin
            bad++;
            $display("FAIL fill_reject got v=%0b cnt=%0d want 0/4", out_valid, count);
        end
        res_v[0] = 1'b1; res_r[0] = 5'd5; res_d[0] = 32'hA0;
        tick(); clear_in();
        total++;
        if ({out_valid, out_opA, count, in_ready} !== {1'b1, 32'hA0, 3'd4, 1'b0}) begin
            bad++;
            $display("FAIL fill_head got v=%0b a=%h cnt=%0d rdy=%0b want 1/a0/4/0", out_valid, out_opA, count, in_ready);
        end
        // offered while full and dequeuing: must wait one cycle, then enter once
        in_valid = 1'b1; in_opA = 32'h200; in_payload = 16'hB004;
        exp_a[0] = 32'h101; exp_a[1] = 32'h102; exp_a[2] = 32'h103; exp_a[3] = 32'h200;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 1) clear_in();
            total++;
            if ({out_valid, out_opA, count} !== {1'b1, exp_a[i], (i < 2) ? 3'd3 : 3'(4 - i)}) begin
                bad++;
                $display("FAIL fill_order%0d got v=%0b a=%h cnt=%0d want 1/%h/%0d",
                         i, out_valid, out_opA, count, exp_a[i], (i < 2) ? 3 : 4 - i);
            end
        end
        tick();
        total++;
        if ({out_valid, count, in_ready} !== {1'b0, 3'd0, 1'b1}) begin
            bad++;
            $display("FAIL fill_empty got v=%0b cnt=%0d rdy=%0b want 0/0/1", out_valid, count, in_ready);
        end
        $display("fill_wrap: released a0 101 102 103 200");
    endtask

    task automatic test_flush();
        clear_in(); out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1; in_opA = 32'h300 + 32'(i);
            tick();
        end
        clear_in();
        total++;
        if ({count, out_valid, out_opA} !== {3'd4, 1'b1, 32'h300}) begin
            bad++;
            $display("FAIL flush_pre got cnt=%0d v=%0b a=%h want 4/1/300", count, out_valid, out_opA);
        end
        flush = 1'b1; in_valid = 1'b1; in_opA = 32'h333;
        tick(); clear_in();
        total++;
        if ({count, out_valid, out_opA, in_ready} !== {3'd0, 1'b0, 32'h0, 1'b1}) begin
            bad++;
            $display("FAIL flush_clear got cnt=%0d v=%0b a=%h rdy=%0b want 0/0/0/1", count, out_valid, out_opA, in_ready);
        end
        tick();
        total++;
        if ({count, out_valid} !== {3'd0, 1'b0}) begin
            bad++;
            $display("FAIL flush_drop got cnt=%0d v=%0b want 0/0", count, out_valid);
        end
        $display("flush: cnt=%0d", count);
    endtask

    task automatic test_reg0();
        clear_in(); out_ready = 1'b0;
        in_valid = 1'b1; in_pendA = 1'b1; in_regA = 5'd0; in_fuA = 3'd1; in_opA = 32'h5555; in_opB = 32'h66;
        tick(); clear_in();
        total++;
        if ({out_valid, out_opA, out_opB} !== {1'b1, 32'h0, 32'h66}) begin
            bad++;
            $display("FAIL reg0_out got v=%0b a=%h b=%h want 1/0/66", out_valid, out_opA, out_opB);
        end
        out_ready = 1'b1;
        tick();
        total++;
        if (count !== 3'd0) begin
            bad++;
            $display("FAIL reg0_drain got cnt=%0d want 0", count);
        end
        $display("reg0: a=0 resolved");
    endtask

    task automatic test_random();
        bit            ev;
        logic [DW-1:0] ea, eb;
        logic [PW-1:0] ep;
        int            errs;
        errs = 0;
        for (int n = 0; n < 600; n++) begin
            in_valid   = ($urandom_range(0, 99) < 60);
            in_pendA   = $urandom_range(0, 1) == 1;
            in_pendB   = $urandom_range(0, 2) == 0;
            in_regA    = 5'($urandom_range(0, 7));
            in_regB    = 5'($urandom_range(0, 7));
            in_fuA     = 3'($urandom_range(0, NCH - 1));
            in_fuB     = 3'($urandom_range(0, NCH - 1));
            in_opA     = $urandom;
            in_opB     = $urandom;
            in_payload = 16'($urandom);
            out_ready  = ($urandom_range(0, 99) < 70);
            flush      = ($urandom_range(0, 59) == 0);
            for (int c = 0; c < NCH; c++) begin
                res_v[c] = ($urandom_range(0, 99) < 40);
                res_r[c] = 5'($urandom_range(0, 7));
                res_d[c] = $urandom;
            end
            tick();
            ev = mq.size() > 0 && !mq[0].pa && !mq[0].pb;
            ea = ev ? mq[0].opa : '0;
            eb = ev ? mq[0].opb : '0;
            ep = ev ? mq[0].pl  : '0;
            total++;
            if ({in_ready, out_valid, count, out_opA, out_opB, out_payload} !==
                {(mq.size() < DEPTH), ev, 3'(mq.size()), ea, eb, ep}) begin
                bad++; errs++;
                $display("FAIL random_cyc%0d got rdy=%0b v=%0b cnt=%0d a=%h b=%h p=%h want rdy=%0b v=%0b cnt=%0d a=%h b=%h p=%h",
                         n, in_ready, out_valid, count, out_opA, out_opB, out_payload,
                         mq.size() < DEPTH, ev, mq.size(), ea, eb, ep);
            end
        end
        clear_in();
        $display("random: 600 cycles, %0d errors", errs);
    endtask

    initial begin
        clear_in();
        test_reset();
        test_passthru();
        test_late_bru();
        test_enq_capture();
        test_fill_wrap();
        test_flush();
        test_reg0();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
